// File: rtl/debug_tx_serializer_if.sv
// Response handshake between the debug controller and the UART transmit serializer.
// The controller drives the master side and the serializer implements the slave side.
interface debug_tx_serializer_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [2:0]  tx_len;

  modport master (output tx_valid, output tx_data, output tx_len, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_len, output tx_ready);
endinterface

// File: rtl/debug_tx_serializer.sv
// UART transmit serializer for the debug link: sends 1..4 response bytes MSB-byte first as 8N1.
// Defining DEBUG_TX_PARITY_EN adds an even-parity bit to each byte, which makes the frame 8E1.
module debug_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  IDLE_ACK     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  debug_tx_serializer_if.slave  tx,
  output logic                  stx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef DEBUG_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] bit_timer;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_cnt;
  logic [31:0] word_sr;
  logic        ready_q;

  logic       bit_end;
  logic [7:0] cur_byte;
  logic [2:0] next_idx;
  logic [2:0] len_clamped;

  assign bit_end  = (bit_timer == BIT_LAST);
  assign cur_byte = word_sr[31:24];
  assign next_idx = bit_idx + 3'd1;

  // A zero length means a bare acknowledge of one byte. Anything above four is capped at four.
  assign len_clamped = (tx.tx_len == 3'd0) ? 3'd1 :
                       (tx.tx_len > 3'd4)  ? 3'd4 : tx.tx_len;

  assign tx.tx_ready = ready_q;

  // NOTE: all state uses non-blocking assignments, so every register sees values from before the edge.
  // NOTE: the async reset returns stx high immediately, which abandons any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      word_sr   <= '0;
      ready_q   <= 1'b0;
      stx       <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (state == S_IDLE || state == S_DONE || bit_end) bit_timer <= '0;
      else                                               bit_timer <= bit_timer + 16'd1;

      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (tx.tx_valid && ready_q) begin
            ready_q  <= 1'b0;
            tx_busy  <= 1'b1;
            stx      <= 1'b0;
            bit_idx  <= '0;
            byte_cnt <= len_clamped;
            word_sr  <= (tx.tx_len == 3'd0) ? {IDLE_ACK, 24'h0} : tx.tx_data;
            state    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            stx     <= cur_byte[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef DEBUG_TX_PARITY_EN
              stx   <= ^cur_byte;
              state <= S_PARITY;
`else
              stx   <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= next_idx;
              stx     <= cur_byte[next_idx];
            end
          end
        end

`ifdef DEBUG_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            stx   <= 1'b1;
            state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            if (byte_cnt > 3'd1) begin
              // Go straight into the next start bit, so there is no idle gap between bytes.
              byte_cnt <= byte_cnt - 3'd1;
              word_sr  <= {word_sr[23:0], 8'h00};
              stx      <= 1'b0;
              state    <= S_START;
            end else begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= S_DONE;
            end
          end
        end

        S_DONE: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Self-checking bench for debug_tx_serializer running with CLKS_PER_BIT=4. It compares every cycle against
// a bit-list model of the line, decodes the line the way a host UART would, and covers reset and handshake corner cases.
module tb_debug_tx_serializer;

  localparam int CPB = 4;
`ifdef DEBUG_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stx, tx_busy, tx_done;

  debug_tx_serializer_if bus ();

  debug_tx_serializer #(.CLKS_PER_BIT(CPB), .IDLE_ACK(8'hA5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx      (bus),
    .stx     (stx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_bytes[$];
  logic [7:0] got[$];
  bit         wave[$];
  bit         rx_bits[$];

  typedef struct {
    logic [31:0] data;
    logic [2:0]  len;
    int          n;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the byte list from the length rules, then the line level for every clock cycle.
  function automatic void build_model(input logic [31:0] d, input logic [2:0] l);
    int n;
    logic [7:0] b;
    exp_bytes.delete();
    wave.delete();
    if (l == 3'd0) exp_bytes.push_back(8'hA5);
    else begin
      n = (l > 3'd4) ? 4 : int'(l);
      for (int i = 0; i < n; i++) exp_bytes.push_back(d[31 - 8*i -: 8]);
    end
    foreach (exp_bytes[i]) begin
      b = exp_bytes[i];
      for (int k = 0; k < CPB; k++) wave.push_back(1'b0);
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < CPB; k++) wave.push_back(b[j]);
      if (FRAME_BITS == 11)
        for (int k = 0; k < CPB; k++) wave.push_back(^b);
      for (int k = 0; k < CPB; k++) wave.push_back(1'b1);
    end
  endfunction

  // Host-side UART receiver. It looks for a start edge and then samples each bit at its midpoint.
  function automatic void decode();
    int i = 0;
    logic [7:0] b;
    got.delete();
    while (i < rx_bits.size()) begin
      if (rx_bits[i] == 1'b0 && i + CPB/2 + 8*CPB < rx_bits.size()) begin
        for (int k = 0; k < 8; k++) b[k] = rx_bits[i + CPB/2 + (k+1)*CPB];
        got.push_back(b);
        i += FRAME_BITS * CPB;
      end else begin
        i++;
      end
    end
  endfunction

  // Called at a negedge. With stress set, tx_valid stays high and the data and length inputs are
  // changed after the accepting edge, so the caller's next send starts on the cycle after tx_done.
  task automatic send(input logic [31:0] d, input logic [2:0] l, input bit stress);
    int wait_cnt;
    int n_cyc;
    build_model(d, l);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.tx_len   = l;
    wait_cnt = 0;
    while (bus.tx_ready !== 1'b1 && wait_cnt < 400) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (bus.tx_ready !== 1'b1) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.tx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (stress) begin
      bus.tx_data = 32'hFFFFFFFF;
      bus.tx_len  = 3'd1;
    end else begin
      bus.tx_valid = 1'b0;
    end
    n_cyc = wave.size();
    rx_bits.delete();
    for (int c = 0; c <= n_cyc + 1; c++) begin
      if (c > 0) @(negedge clk);
      rx_bits.push_back(stx);
      check("stx",   32'(stx),     (c < n_cyc) ? 32'(wave[c]) : 32'd1);
      check("busy",  32'(tx_busy), (c < n_cyc) ? 32'd1 : 32'd0);
      check("done",  32'(tx_done), (c == n_cyc) ? 32'd1 : 32'd0);
      check("ready", 32'(bus.tx_ready), (c == n_cyc + 1) ? 32'd1 : 32'd0);
    end
    decode();
    check("byte_count", got.size(), exp_bytes.size());
    foreach (exp_bytes[i])
      if (i < got.size()) check("byte", 32'(got[i]), 32'(exp_bytes[i]));
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h5A000000, 3'd1, 1, 32'h5A000000};
    vecs[1] = '{32'hDEADBEEF, 3'd4, 4, 32'hDEADBEEF};
    vecs[2] = '{32'h12345678, 3'd0, 1, 32'hA5000000};
    vecs[3] = '{32'h01020304, 3'd7, 4, 32'h01020304};
    vecs[4] = '{32'h12345678, 3'd2, 2, 32'h12340000};
    vecs[5] = '{32'h0000C3FF, 3'd5, 4, 32'h0000C3FF};

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.tx_len   = '0;

    // Reset: every output is held while reset is asserted, and tx_ready rises on the first edge after release.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_stx",   32'(stx),          32'd1);
      check("rst_ready", 32'(bus.tx_ready), 32'd0);
      check("rst_busy",  32'(tx_busy),      32'd0);
      check("rst_done",  32'(tx_done),      32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.tx_ready), 32'd1);
    check("post_rst_stx",   32'(stx),          32'd1);
    check("post_rst_busy",  32'(tx_busy),      32'd0);

    // The table vectors also check the decoded bytes against the constants written above.
    foreach (vecs[v]) begin
      send(vecs[v].data, vecs[v].len, 1'b0);
      check("tbl_n", got.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n; i++)
        if (i < got.size()) check("tbl_byte", 32'(got[i]), 32'(vecs[v].exp[31 - 8*i -: 8]));
      @(negedge clk);
    end

    // Backpressure: the inputs change mid-frame and tx_valid stays high. The next send checks its timing.
    send(32'hC0FFEE11, 3'd2, 1'b1);
    send(32'hFFFFFFFF, 3'd1, 1'b0);

    // Reset mid-frame during data bit 3 of the first byte.
    build_model(32'hDEADBEEF, 3'd4);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 32'hDEADBEEF;
    bus.tx_len   = 3'd4;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    for (int c = 1; c <= 17; c++) @(negedge clk);
    check("pre_rst_stx", 32'(stx), 32'(wave[17]));
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_stx",   32'(stx),          32'd1);
    check("async_rst_busy",  32'(tx_busy),      32'd0);
    check("async_rst_ready", 32'(bus.tx_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_done", 32'(tx_done), 32'd0);
      check("rst_hold_stx",  32'(stx),     32'd1);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("rerst_ready", 32'(bus.tx_ready), 32'd1);
    check("rerst_done",  32'(tx_done),      32'd0);
    send(32'h3C000000, 3'd1, 1'b0);
    if (got.size() > 0) check("after_rst_3c", 32'(got[0]), 32'h3C);
    else                check("after_rst_3c", 32'hFFFFFFFF, 32'h3C);

    // Random responses with random idle gaps, each checked against the model.
    for (int t = 0; t < 25; t++) begin
      logic [31:0] d;
      logic [2:0]  l;
      d = $urandom;
      l = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(d, l, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_tx_serializer.md
Name: debug_tx_serializer

Overview:
- UART transmit side of the debugger's serial link: returns controller read data and acknowledgements to the host over stx.
- Accepts a 32-bit response word and a byte count from the controller through a valid/ready handshake.
- Frames each byte as 8N1, most-significant byte first, and pulses tx_done when the last stop bit completes.
- Sits beside the serial command decoder: the decoder owns srx, this block owns stx.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- IDLE_ACK, 8'hA5, byte value sent when tx_len = 0 (bare command acknowledge).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tx_valid  input  1  controller has a response to send
- tx_ready  output  1  serializer can accept a response
- tx_data  input  32  response word; byte 3 ([31:24]) is sent first
- tx_len  input  3  number of bytes to send, 0..4
- stx  output  1  UART serial out, idle high
- tx_busy  output  1  frame transmission in progress
- tx_done  output  1  one-cycle pulse after the final stop bit

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is asynchronous and active-low on reset_n.
  - While reset_n = 0: stx = 1, tx_ready = 0, tx_busy = 0, tx_done = 0; all counters clear; state = IDLE.
  - tx_ready rises on the first clk edge after reset_n deasserts.
- Handshake:
  - Transfer occurs at a clk edge where tx_valid & tx_ready.
  - At that edge tx_data and tx_len are latched; later changes on the inputs are ignored.
  - tx_ready = 1 only in IDLE and drops on the accepting edge.
  - tx_valid asserted while tx_ready = 0 is held off with no effect.
- Length rules:
  - tx_len 1..4: send bytes tx_data[31:24] downward, tx_len bytes total (for example, len 2 sends [31:24] then [23:16]).
  - tx_len 0: send the single byte IDLE_ACK.
  - tx_len 5..7: clamp to 4.
- States:
  - IDLE -> START on a transfer. stx, a registered output, goes low at the accepting edge.
  - START: stx = 0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. After bit 7 -> STOP, or -> PARITY when the optional feature is enabled.
  - STOP: stx = 1 for CLKS_PER_BIT cycles.
    - If bytes remain: decrement the byte counter, shift in the next byte, -> START. There is no extra idle gap between bytes.
    - Otherwise -> DONE.
  - DONE: tx_done = 1 for exactly one cycle, stx = 1, -> IDLE. tx_ready is 1 on the following cycle.
- Timing:
  - Bit-timer counter runs 0..CLKS_PER_BIT-1 and reloads on each bit boundary.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Frame time is n·10·CLKS_PER_BIT cycles, plus 1 DONE cycle, measured from the accepting edge.
- tx_busy = 1 in START, DATA, PARITY and STOP. It is 0 in IDLE and DONE.
- Reset mid-frame: the frame is abandoned and stx returns high immediately (asynchronously). No tx_done is issued.
- The byte counter must not wrap. Exactly the requested number of frames is emitted.

Optional Feature:
- Macro: DEBUG_TX_PARITY_EN.
- With DEBUG_TX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 8E1 frame of 11 bits per byte.
- Without the macro: 8N1 only; no PARITY state or parity logic is synthesized.

Test Plan:
- Reset check (CLKS_PER_BIT=4): hold reset_n=0 for 5 cycles, then release -> stx=1 throughout; tx_ready=1 on the 1st edge after release; tx_busy=0; tx_done=0.
- Single byte (CLKS_PER_BIT=4): tx_data=32'h5A000000, tx_len=1 -> stx sequence 0,0,1,0,1,1,0,1,0,1, each bit 4 cycles; tx_done pulses at cycle 41; tx_ready=1 at cycle 42.
- Full word (CLKS_PER_BIT=4): tx_data=32'hDEADBEEF, tx_len=4 -> host model decodes DE,AD,BE,EF in order; 160 cycles with stx never idle between frames; exactly one tx_done.
- Ack and clamp: tx_len=0 -> single byte A5 decoded; then tx_len=7, tx_data=32'h01020304 -> 01,02,03,04, four bytes only.
- Backpressure and stability: change tx_data to 32'hFFFFFFFF mid-frame and hold tx_valid=1 -> current frame unchanged; second response accepted only on the cycle after tx_done.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 -> stx=1 asynchronously in the same cycle; no tx_done; after release, a len=1 tx_data=32'h3C000000 send decodes 3C correctly (with DEBUG_TX_PARITY_EN: parity bit = 0 for 3C, 11-bit frame).
